// File: rtl/pla_term_loader.sv
// PLA AND-plane term-mask loader: one accepted cfg word per term, SETUP/STROBE/HOLD per write.
// Optional build macro PLA_CFG_PARITY_EN adds an even-parity bit on cfg_data and a sticky cfg_err.
module pla_term_loader #(
  parameter int NUM_INPUTS = 5,
  parameter int NUM_TERMS  = 8,
  parameter int IDX_W      = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
`ifdef PLA_CFG_PARITY_EN
  input  logic [NUM_INPUTS:0]   cfg_data,
`else
  input  logic [NUM_INPUTS-1:0] cfg_data,
`endif
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  output logic [NUM_INPUTS-1:0] sel,
  output logic [NUM_TERMS-1:0]  wen,
  output logic [IDX_W-1:0]      term_idx,
  output logic                  busy,
  output logic                  done
`ifdef PLA_CFG_PARITY_EN
  ,
  output logic                  cfg_err
`endif
);

  typedef enum logic [2:0] {IDLE, LOAD, SETUP, STROBE, HOLD} state_t;

  state_t state, next_state;
  logic   accept;
  logic   last_term;
  logic   par_bad;

`ifdef PLA_CFG_PARITY_EN
  assign par_bad = ^cfg_data;
`else
  assign par_bad = 1'b0;
`endif

  assign accept    = cfg_valid & cfg_ready;
  assign last_term = (term_idx == IDX_W'(NUM_TERMS - 1));

  // State register plus the registered datapath (sel, strobes, index, done).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      sel      <= '0;
      wen      <= '0;
      term_idx <= '0;
      done     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state <= next_state;
      done  <= (state == HOLD) && last_term && !abort;
      // Strobe is a flop decoded from next_state, so it is glitch-free and exactly one cycle.
      wen   <= (next_state == STROBE) ? (NUM_TERMS'(1) << term_idx) : '0;
      if (accept && !par_bad) begin
        sel <= cfg_data[NUM_INPUTS-1:0];
      end
      if (next_state == IDLE) begin
        term_idx <= '0;
      end else if (state == HOLD) begin
        term_idx <= term_idx + 1'b1;
      end
    end
  end

`ifdef PLA_CFG_PARITY_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cfg_err <= 1'b0;
    end else if (state == IDLE && start) begin
      cfg_err <= 1'b0;
    end else if (accept && par_bad) begin
      cfg_err <= 1'b1;
    end
  end
`endif

  always_comb begin
    // NOTE: default first so every path assigns next_state and no latch is inferred.
    next_state = state;
    if (abort && state != IDLE) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) next_state = LOAD;
        LOAD:    if (accept) next_state = par_bad ? IDLE : SETUP;
        SETUP:   next_state = STROBE;
        STROBE:  next_state = HOLD;
        HOLD:    next_state = last_term ? IDLE : LOAD;
        default: next_state = IDLE;
      endcase
    end
  end

  // Abort outranks the handshake, so ready drops in the same cycle abort is seen.
  always_comb begin
    cfg_ready = (state == LOAD) && !abort;
    busy      = (state != IDLE);
  end

endmodule

// File: tb/tb_pla_term_loader.sv
// Self-checking bench for pla_term_loader: latency-based reference model checked every cycle,
// a modelled bank of terms latching sel on their strobe, and literal expectations per scenario.
module tb_pla_term_loader;
  localparam int NI = 5;
  localparam int NT = 8;
  localparam int IW = 3;
`ifdef PLA_CFG_PARITY_EN
  localparam int DW = NI + 1;
`else
  localparam int DW = NI;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          cfg_valid = 1'b0;
  logic [DW-1:0] cfg_data = '0;
  logic          cfg_ready;
  logic [NI-1:0] sel;
  logic [NT-1:0] wen;
  logic [IW-1:0] term_idx;
  logic          busy;
  logic          done;
`ifdef PLA_CFG_PARITY_EN
  logic          cfg_err;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  pla_term_loader #(.NUM_INPUTS(NI), .NUM_TERMS(NT), .IDX_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .sel(sel), .wen(wen), .term_idx(term_idx), .busy(busy), .done(done)
`ifdef PLA_CFG_PARITY_EN
    , .cfg_err(cfg_err)
`endif
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Term bank: each term captures the shared bus on the rising edge of its own strobe.
  logic [NI-1:0] term_mask [NT];
  initial for (int k = 0; k < NT; k++) term_mask[k] = '0;
  for (genvar g = 0; g < NT; g++) begin : g_term
    always @(posedge wen[g]) term_mask[g] <= sel;
  end

  // Reference model: a sequence is "active"; m_age counts cycles since the current word was
  // accepted (-1 while waiting for a word). Strobe is at age 2, next word wanted after age 3.
  bit            m_active = 1'b0;
  bit            m_done = 1'b0;
  bit            m_err = 1'b0;
  int            m_age = -1;
  int            m_idx = 0;
  logic [NI-1:0] m_sel = '0;

  function automatic bit bad_parity(input logic [DW-1:0] d);
    return (DW > NI) ? ^d : 1'b0;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      m_active <= 1'b0; m_done <= 1'b0; m_err <= 1'b0;
      m_age <= -1; m_idx <= 0; m_sel <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_active && abort) begin
        m_active <= 1'b0; m_idx <= 0; m_age <= -1;
      end else if (!m_active) begin
        if (start) begin
          m_active <= 1'b1; m_age <= -1; m_idx <= 0; m_err <= 1'b0;
        end
      end else if (m_age < 0) begin
        if (cfg_valid) begin
          if (bad_parity(cfg_data)) begin
            m_err <= 1'b1; m_active <= 1'b0; m_idx <= 0;
          end else begin
            m_sel <= cfg_data[NI-1:0]; m_age <= 1;
          end
        end
      end else if (m_age < 3) begin
        m_age <= m_age + 1;
      end else if (m_idx == NT - 1) begin
        m_done <= 1'b1; m_active <= 1'b0; m_idx <= 0; m_age <= -1;
      end else begin
        m_idx <= m_idx + 1; m_age <= -1;
      end
    end
  end

  logic [NI-1:0] prev_sel = '0;
  logic [NT-1:0] prev_wen = '0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("cfg_ready", cfg_ready, m_active && m_age < 0 && !abort);
      check("busy", busy, m_active);
      check("term_idx", term_idx, m_idx);
      check("sel", sel, m_sel);
      check("done", done, m_done);
      check("wen", wen, (m_active && m_age == 2) ? (32'd1 << m_idx) : 32'd0);
`ifdef PLA_CFG_PARITY_EN
      check("cfg_err", cfg_err, m_err);
`endif
      check("wen_onehot0", $onehot0(wen), 1);
      if (wen != '0 || prev_wen != '0) check("sel_stable_around_strobe", sel, prev_sel);
      if (done) done_cnt++;
    end
    prev_sel = sel;
    prev_wen = wen;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Offer one word and return the cycle count at which it was consumed.
  task automatic send_word(input logic [DW-1:0] w, output int acc_cyc);
    bit ok;
    ok = 1'b0;
    cfg_data = w;
    cfg_valid = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (cfg_ready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    acc_cyc = cyc;
    if (!ok) check("handshake_timeout", ok, 1);
  endtask

  function automatic logic [DW-1:0] mkw(input logic [NI-1:0] m);
    logic [NI:0] t;
    t = {^m, m};
    return t[DW-1:0];
  endfunction

  logic [NI-1:0] words1 [NT] = '{5'h03, 5'h1F, 5'h05, 5'h0A, 5'h11, 5'h1C, 5'h07, 5'h18};
  logic [NI-1:0] words2 [NT] = '{5'h01, 5'h02, 5'h04, 5'h08, 5'h10, 5'h06, 5'h0C, 5'h19};
  logic [NI-1:0] words3 [5]  = '{5'h13, 5'h0E, 5'h15, 5'h1A, 5'h09};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t_acc [NT];
    int t;
    int d0;

    rst_n = 1'b0;
    tick(2);
    chk_en = 1'b1;
    check("reset_sel", sel, 0);
    check("reset_wen", wen, 0);
    check("reset_busy", busy, 0);
    check("reset_ready", cfg_ready, 0);
    rst_n = 1'b1;
    tick(2);

    // 1: full sequence with cfg_valid held high
    d0 = done_cnt;
    do_start();
    for (int k = 0; k < NT; k++) send_word(mkw(words1[k]), t_acc[k]);
    tick(4);
    cfg_valid = 1'b0;
    for (int k = 1; k < NT; k++) check("ready_period", t_acc[k] - t_acc[k-1], 4);
    for (int k = 0; k < NT; k++) check("t1_term_mask", term_mask[k], words1[k]);
    check("t1_done_once", done_cnt - d0, 1);
    check("t1_busy_low", busy, 0);

    // 2: valid withheld before word 3
    d0 = done_cnt;
    do_start();
    for (int k = 0; k < 3; k++) send_word(mkw(words2[k]), t);
    cfg_valid = 1'b0;
    tick(13);
    check("t2_wait_wen", wen, 0);
    check("t2_wait_sel", sel, 5'h04);
    check("t2_wait_ready", cfg_ready, 1);
    check("t2_wait_idx", term_idx, 3);
    for (int k = 3; k < NT; k++) send_word(mkw(words2[k]), t);
    cfg_valid = 1'b0;
    tick(5);
    for (int k = 0; k < NT; k++) check("t2_term_mask", term_mask[k], words2[k]);
    check("t2_done_once", done_cnt - d0, 1);

    // 3: abort during STROBE of term 4
    d0 = done_cnt;
    do_start();
    for (int k = 0; k < 5; k++) send_word(mkw(words3[k]), t);
    cfg_valid = 1'b0;
    tick(1);
    check("t3_strobe4", wen, 8'h10);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check("t3_wen_after_abort", wen, 0);
    tick(3);
    check("t3_idx", term_idx, 0);
    check("t3_busy", busy, 0);
    check("t3_no_done", done_cnt - d0, 0);
    check("t3_term4", term_mask[4], 5'h09);
    check("t3_term5", term_mask[5], 5'h06);
    check("t3_term6", term_mask[6], 5'h0C);
    check("t3_term7", term_mask[7], 5'h19);

    // 4: start while busy is ignored; reset during SETUP
    do_start();
    tick(2);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check("t4_busy", busy, 1);
    check("t4_idx", term_idx, 0);
    send_word(mkw(5'h1E), t);
    cfg_valid = 1'b0;
    check("t4_setup_sel", sel, 5'h1E);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    check("t4_sel", sel, 0);
    check("t4_wen", wen, 0);
    check("t4_ready", cfg_ready, 0);
    check("t4_idx_rst", term_idx, 0);
    check("t4_busy_rst", busy, 0);
    check("t4_done", done, 0);
    tick(3);
    check("t4_term0_untouched", term_mask[0], 5'h13);

`ifdef PLA_CFG_PARITY_EN
    // 5: bad parity word is consumed without a strobe
    do_start();
    send_word(6'h07, t);
    cfg_valid = 1'b0;
    check("t5_err", cfg_err, 1);
    check("t5_busy", busy, 0);
    tick(4);
    check("t5_term0", term_mask[0], 5'h13);
    do_start();
    check("t5_err_clear", cfg_err, 0);
    send_word(mkw(5'h07), t);
    cfg_valid = 1'b0;
    tick(2);
    check("t5_term0_good", term_mask[0], 5'h07);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    tick(2);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
